spi_master_ctrl: RTL and testbench

//   Synthesizable SPI master that turns parallel words into SPI transfers: drives sclk/mosi/ss,

---
 rtl/spi_master_ctrl_if.sv | 25 ++
 rtl/spi_master_ctrl.sv | 161 ++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// Parallel request/response handshake plus the SPI pins of spi_master_ctrl.
// master: the controller; slave: whoever drives requests and models the SPI device.
interface spi_master_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  ss;

  modport master (
    input  tx_data, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, sclk, mosi, ss
  );

  modport slave (
    output tx_data, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, sclk, mosi, ss
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: one parallel word in, one full-duplex MSB-first transfer out, received word back.
// Any CPOL/CPHA mode; every output comes straight from a register.
//
// state | meaning
// IDLE  | ready for a word, ss high, sclk at CPOL
// SETUP | ss low, first bit settling before edge 1
// XFER  | sclk toggling, 2*DATA_WIDTH edges
// HOLD  | sclk back at CPOL, ss still low
// GAP   | ss high, rx_valid pulse, minimum deselect time
module spi_master_ctrl #(
  parameter int CLK_POLARITY = 0,
  parameter int CLK_PHASE    = 0,
  parameter int DATA_WIDTH   = 16,
  parameter int CLK_DIV      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_ctrl_if.master bus
);

  localparam int DIVW = $clog2(CLK_DIV);
  localparam int EDGW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIV - 1);
  localparam logic [EDGW-1:0] EDGE_LAST = EDGW'(2 * DATA_WIDTH);
  localparam logic CPOL = 1'(CLK_POLARITY);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t                state_q, state_d;
  logic [DIVW-1:0]       div_q, div_d;
  logic [EDGW-1:0]       edge_q, edge_d;
  logic                  sclk_q, sclk_d;
  logic                  ss_q, ss_d;
  logic                  mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_ready_q, tx_ready_d;

  logic            tick;
  logic [EDGW-1:0] edge_k;
  logic            leading;
  logic            sample_now;
  logic            shift_now;

  assign tick    = (div_q == DIV_LAST);
  assign edge_k  = edge_q + EDGW'(1);
  assign leading = edge_k[0];
  assign sample_now = (CLK_PHASE == 0) ? leading : !leading;
  // CPHA=0 already drove the MSB in SETUP, so the final trailing edge has nothing left to shift
  assign shift_now  = (CLK_PHASE == 0) ? (!leading && (edge_k != EDGE_LAST)) : leading;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      edge_q     <= '0;
      sclk_q     <= CPOL;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    edge_d     = edge_q;
    sclk_d     = sclk_q;
    ss_d       = ss_q;
    mosi_d     = mosi_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready_d = tx_ready_q;

    if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + DIVW'(1);
    end

    case (state_q)
      IDLE: begin
        tx_ready_d = 1'b1;
        ss_d       = 1'b1;
        sclk_d     = CPOL;
        mosi_d     = 1'b0;
        div_d      = '0;
        edge_d     = '0;
        if (bus.tx_valid && tx_ready_q) begin
          tx_ready_d = 1'b0;
          ss_d       = 1'b0;
          rx_sh_d    = '0;
          state_d    = SETUP;
          if (CLK_PHASE == 0) begin
            mosi_d  = bus.tx_data[DATA_WIDTH-1];
            tx_sh_d = {bus.tx_data[DATA_WIDTH-2:0], 1'b0};
          end else begin
            tx_sh_d = bus.tx_data;
          end
        end
      end
      SETUP, XFER: begin
        if (tick) begin
          edge_d = edge_k;
          sclk_d = ~sclk_q;
          if (sample_now) begin
            rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], bus.miso};
          end
          if (shift_now) begin
            mosi_d  = tx_sh_q[DATA_WIDTH-1];
            tx_sh_d = tx_sh_q << 1;
          end
          state_d = (edge_k == EDGE_LAST) ? HOLD : XFER;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d    = GAP;
          ss_d       = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
          state_d    = IDLE;
          tx_ready_d = 1'b1;
          edge_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;
  assign bus.ss       = ss_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: one instance per CPOL/CPHA mode, each wired to a small SPI slave model.
// Expected words are queued when a transfer is launched and checked when rx_valid or a slave frame appears.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          mode;
    logic [15:0] data;
  } exp_t;

  exp_t exp_rx_q[$];
  exp_t exp_bfm_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] tx_data_m [4];
  logic        tx_valid_m[4];
  logic [15:0] bfm_word_m[4];

  wire         tx_ready_m[4];
  wire         rx_valid_m[4];
  wire  [15:0] rx_data_m [4];
  wire         sclk_m    [4];
  wire         mosi_m    [4];
  wire         ss_m      [4];
  wire         frame_v_m [4];
  wire  [15:0] frame_m   [4];

  int   ss_low[4], rises[4], rxv[4], frames[4], ready_busy[4], hi_run[4], last_gap[4];
  logic xbad[4];
  logic prev_sclk[4];

  for (genvar g = 0; g < 4; g++) begin : g_mode
    localparam int CPOL = g / 2;
    localparam int CPHA = g % 2;

    spi_master_ctrl_if #(.DATA_WIDTH(16)) bus ();

    spi_master_ctrl #(
      .CLK_POLARITY(CPOL),
      .CLK_PHASE   (CPHA),
      .DATA_WIDTH  (16),
      .CLK_DIV     (4)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    logic [15:0] s_tx = '0;
    logic [15:0] s_rx = '0;
    int          s_bits = 0;
    logic        p_sclk = 1'(CPOL);
    logic        p_ss = 1'b1;
    logic        s_miso = 1'b0;
    logic        fv = 1'b0;
    logic [15:0] fw = '0;

    assign bus.tx_data  = tx_data_m[g];
    assign bus.tx_valid = tx_valid_m[g];
    assign bus.miso     = s_miso;
    assign tx_ready_m[g] = bus.tx_ready;
    assign rx_valid_m[g] = bus.rx_valid;
    assign rx_data_m[g]  = bus.rx_data;
    assign sclk_m[g]     = bus.sclk;
    assign mosi_m[g]     = bus.mosi;
    assign ss_m[g]       = bus.ss;
    assign frame_v_m[g]  = fv;
    assign frame_m[g]    = fw;

    // Slave device: reports a frame only when a full 16 bits were clocked before ss rose
    always @(negedge clk) begin
      p_sclk <= bus.sclk;
      p_ss   <= bus.ss;
      fv     <= 1'b0;
      if (bus.ss !== 1'b0) begin
        s_bits <= 0;
        if (p_ss === 1'b0 && s_bits == 16) begin
          fv <= 1'b1;
          fw <= s_rx;
        end
      end else if (p_ss === 1'b1) begin
        s_rx <= '0;
        if (CPHA == 0) begin
          s_miso <= bfm_word_m[g][15];
          s_tx   <= bfm_word_m[g] << 1;
        end else begin
          s_miso <= 1'b0;
          s_tx   <= bfm_word_m[g];
        end
      end else if (bus.sclk !== p_sclk) begin
        if ((bus.sclk != 1'(CPOL)) == (CPHA == 0)) begin
          s_rx   <= {s_rx[14:0], bus.mosi};
          s_bits <= s_bits + 1;
        end else begin
          s_miso <= s_tx[15];
          s_tx   <= s_tx << 1;
        end
      end
    end
  end

  task automatic clear_stats();
    for (int m = 0; m < 4; m++) begin
      ss_low[m] = 0; rises[m] = 0; rxv[m] = 0; frames[m] = 0;
      ready_busy[m] = 0; hi_run[m] = 0; last_gap[m] = -1; xbad[m] = 1'b0;
      prev_sclk[m] = sclk_m[m];
    end
  endtask

  // Advance one cycle; score any rx_valid / slave frame against the queues and gather stats.
  task automatic step();
    exp_t e;
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      if (rx_valid_m[m] === 1'b1) begin
        vectors++;
        if (exp_rx_q.size() == 0) begin
          miscompares++;
          $display("FAIL rx_data mode %0d: got %h with nothing expected", m, rx_data_m[m]);
        end else begin
          e = exp_rx_q.pop_front();
          if (e.mode != m || rx_data_m[m] !== e.data) begin
            miscompares++;
            $display("FAIL rx_data mode %0d: got %h, expected %h (mode %0d)", m, rx_data_m[m], e.data, e.mode);
          end
        end
      end
      if (frame_v_m[m] === 1'b1) begin
        vectors++;
        frames[m]++;
        if (exp_bfm_q.size() == 0) begin
          miscompares++;
          $display("FAIL slave_word mode %0d: got %h with nothing expected", m, frame_m[m]);
        end else begin
          e = exp_bfm_q.pop_front();
          if (e.mode != m || frame_m[m] !== e.data) begin
            miscompares++;
            $display("FAIL slave_word mode %0d: got %h, expected %h (mode %0d)", m, frame_m[m], e.data, e.mode);
          end
        end
      end
      if (ss_m[m] === 1'b0) begin
        if (hi_run[m] > 0) last_gap[m] = hi_run[m];
        hi_run[m] = 0;
        ss_low[m]++;
        if (tx_ready_m[m] !== 1'b0) ready_busy[m]++;
      end else begin
        hi_run[m]++;
      end
      if (prev_sclk[m] === 1'b0 && sclk_m[m] === 1'b1) rises[m]++;
      prev_sclk[m] = sclk_m[m];
      if (rx_valid_m[m] === 1'b1) rxv[m]++;
      if ($isunknown({mosi_m[m], sclk_m[m], ss_m[m]})) xbad[m] = 1'b1;
    end
  endtask

  task automatic send(input int m, input logic [15:0] w, input logic [15:0] resp);
    int n = 0;
    bfm_word_m[m] = resp;
    exp_rx_q.push_back('{m, resp});
    exp_bfm_q.push_back('{m, w});
    while (tx_ready_m[m] !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout mode %0d: tx_ready=%b, required 1", m, tx_ready_m[m]);
    end
    tx_data_m[m]  = w;
    tx_valid_m[m] = 1'b1;
    step();
    tx_valid_m[m] = 1'b0;
    tx_data_m[m]  = 16'h0;
  endtask

  task automatic finish_xfer(input int m);
    int n = 0;
    while ((exp_rx_q.size() != 0 || exp_bfm_q.size() != 0 || tx_ready_m[m] !== 1'b1) && n < 600) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 600) begin
      miscompares++;
      $display("FAIL done_timeout mode %0d: %0d rx and %0d slave words outstanding, required 0",
               m, exp_rx_q.size(), exp_bfm_q.size());
    end
  endtask

  task automatic test_reset();
    logic [20:0] got, want;
    rst_n = 1'b0;
    repeat (3) step();
    for (int m = 0; m < 4; m++) begin
      got  = {ss_m[m], sclk_m[m], mosi_m[m], rx_valid_m[m], tx_ready_m[m], rx_data_m[m]};
      want = {1'b1, (m >= 2), 1'b0, 1'b0, 1'b0, 16'h0000};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_state mode %0d: {ss,sclk,mosi,rxv,rdy,rx}=%h, required %h", m, got, want);
      end
    end
    rst_n = 1'b1;
    step();
    for (int m = 0; m < 4; m++) begin
      vectors++;
      if (tx_ready_m[m] !== 1'b1) begin
        miscompares++;
        $display("FAIL ready_after_reset mode %0d: tx_ready=%b, required 1", m, tx_ready_m[m]);
      end
    end
  endtask

  task automatic test_mode0();
    clear_stats();
    send(0, 16'hA5C3, 16'h3C5A);
    finish_xfer(0);
    vectors++;
    if (ss_low[0] != 132 || rises[0] != 16 || rxv[0] != 1) begin
      miscompares++;
      $display("FAIL mode0_timing: ss_low=%0d rises=%0d rx_valid=%0d, required 132 16 1",
               ss_low[0], rises[0], rxv[0]);
    end
  endtask

  task automatic test_modes();
    for (int m = 1; m < 4; m++) begin
      clear_stats();
      send(m, 16'h8001, 16'h7FFE);
      finish_xfer(m);
      vectors++;
      if (sclk_m[m] !== 1'(m >= 2) || rises[m] != 16 || ss_low[m] != 132 || rxv[m] != 1) begin
        miscompares++;
        $display("FAIL mode%0d_shape: sclk_idle=%b rises=%0d ss_low=%0d rx_valid=%0d, required %0d 16 132 1",
                 m, sclk_m[m], rises[m], ss_low[m], rxv[m], (m >= 2));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    clear_stats();
    exp_rx_q.push_back('{0, 16'h5678});
    exp_bfm_q.push_back('{0, 16'h1234});
    exp_rx_q.push_back('{0, 16'h9A0F});
    exp_bfm_q.push_back('{0, 16'hFFFF});
    bfm_word_m[0] = 16'h5678;
    tx_data_m[0]  = 16'h1234;
    tx_valid_m[0] = 1'b1;
    step();
    step();
    bfm_word_m[0] = 16'h9A0F;
    tx_data_m[0]  = 16'hFFFF;
    while (tx_ready_m[0] !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    step();
    tx_valid_m[0] = 1'b0;
    finish_xfer(0);
    vectors++;
    if (last_gap[0] != 5 || ready_busy[0] != 0 || rxv[0] != 2 || ss_low[0] != 264) begin
      miscompares++;
      $display("FAIL back_to_back: gap=%0d ready_busy=%0d rx_valid=%0d ss_low=%0d, required 5 0 2 264",
               last_gap[0], ready_busy[0], rxv[0], ss_low[0]);
    end
  endtask

  task automatic test_busy_input();
    clear_stats();
    send(0, 16'h0F0F, 16'hB44B);
    repeat (40) step();
    tx_data_m[0]  = 16'hDEAD;
    tx_valid_m[0] = 1'b1;
    step();
    tx_valid_m[0] = 1'b0;
    tx_data_m[0]  = 16'h0;
    finish_xfer(0);
    repeat (20) step();
    vectors++;
    if (rxv[0] != 1 || frames[0] != 1) begin
      miscompares++;
      $display("FAIL busy_ignored: rx_valid=%0d slave_frames=%0d, required 1 1", rxv[0], frames[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] got;
    clear_stats();
    bfm_word_m[0] = 16'h2468;
    tx_data_m[0]  = 16'h1357;
    tx_valid_m[0] = 1'b1;
    step();
    tx_valid_m[0] = 1'b0;
    repeat (37) step();
    rst_n = 1'b0;
    step();
    got = {ss_m[0], sclk_m[0], mosi_m[0], rx_valid_m[0]};
    vectors++;
    if (got !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_mid: {ss,sclk,mosi,rxv}=%b, required 1000", got);
    end
    rst_n = 1'b1;
    repeat (10) step();
    vectors++;
    if (rxv[0] != 0 || frames[0] != 0 || tx_ready_m[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_after: rx_valid=%0d frames=%0d tx_ready=%b, required 0 0 1",
               rxv[0], frames[0], tx_ready_m[0]);
    end
    send(0, 16'h00FF, 16'hC3A5);
    finish_xfer(0);
  endtask

  task automatic test_patterns();
    logic [15:0] pats[2];
    pats[0] = 16'h0000;
    pats[1] = 16'hFFFF;
    for (int m = 0; m < 4; m++) begin
      clear_stats();
      for (int p = 0; p < 2; p++) begin
        send(m, pats[p], pats[1-p]);
        finish_xfer(m);
      end
      vectors++;
      if (xbad[m] !== 1'b0 || rxv[m] != 2) begin
        miscompares++;
        $display("FAIL patterns mode %0d: x_seen=%b rx_valid=%0d, required 0 2", m, xbad[m], rxv[m]);
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 4; m++) begin
      tx_data_m[m]  = 16'h0;
      tx_valid_m[m] = 1'b0;
      bfm_word_m[m] = 16'h0;
    end
    clear_stats();
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_busy_input();
    test_reset_mid();
    test_patterns();
    repeat (10) step();
    vectors++;
    if (exp_rx_q.size() != 0 || exp_bfm_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d rx and %0d slave words never seen, required 0",
               exp_rx_q.size(), exp_bfm_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
